pwm_control_unit_v2: RTL and testbench

Global control unit for the PWM generator, the successor of the single-register control unit. It adds a run/stop state machine with an optional external start trigger and graceful stop at period end, plus per-chain run masking and a parametrised stop-state width. It also generates multi-cycle sync pulses from software or external edges, and defers timebase changes until all counters are idle. It sits between the AXI-lite control bus and the timebase and counter chains of one PWM generator.

---
 rtl/pwm_control_unit_v2.sv | 252 +++++++++++++++++++++++++
 tb/tb_pwm_control_unit_v2.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_control_unit_v2.sv
// Global PWM control: AXI-lite register file, run/stop FSM with optional external start,
// deferred timebase loading, per-chain run masking and fixed-length sync pulse generation.
module pwm_control_unit_v2 #(
  parameter int N_CHAINS = 3,
  parameter int STOP_STATE_WIDTH = 12,
  parameter int TB_DIV_WIDTH = 3,
  parameter int SYNC_PULSE_LENGTH = 1,
  parameter logic [STOP_STATE_WIDTH-1:0] INITIAL_STOPPED_STATE = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_CHAINS-1:0]         counter_status,
  input  logic [N_CHAINS-1:0]         period_end,
  input  logic                        ext_start,
  input  logic                        ext_sync,
  output logic [TB_DIV_WIDTH-1:0]     timebase_setting,
  output logic                        timebase_enable,
  output logic                        timebase_external_enable,
  output logic [N_CHAINS-1:0]         counter_run,
  output logic                        sync,
  output logic [STOP_STATE_WIDTH-1:0] counter_stopped_state,
  input  logic                        axi_in_awvalid,
  output logic                        axi_in_awready,
  input  logic [3:0]                  axi_in_awaddr,
  input  logic                        axi_in_wvalid,
  output logic                        axi_in_wready,
  input  logic [31:0]                 axi_in_wdata,
  input  logic [3:0]                  axi_in_wstrb,
  output logic                        axi_in_bvalid,
  input  logic                        axi_in_bready,
  output logic [1:0]                  axi_in_bresp,
  input  logic                        axi_in_arvalid,
  output logic                        axi_in_arready,
  input  logic [3:0]                  axi_in_araddr,
  output logic                        axi_in_rvalid,
  input  logic                        axi_in_rready,
  output logic [31:0]                 axi_in_rdata,
  output logic [1:0]                  axi_in_rresp
);

  localparam int SYNC_CNT_W = $clog2(SYNC_PULSE_LENGTH + 1);
  localparam int CTRL_TB_EN = 3;
  localparam int CTRL_TB_EXT = 4;
  localparam int CTRL_RUN = 5;
  localparam int CTRL_SYNC = 6;
  localparam int CTRL_STOP_MODE = 7;
  localparam int CTRL_EXT_START = 8;
  localparam int CTRL_EXT_SYNC = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [9:0]                  ctrl_q, ctrl_d;
  logic [STOP_STATE_WIDTH-1:0] stop_state_q, stop_state_d;
  logic [N_CHAINS-1:0]         run_mask_q, run_mask_d;
  logic                        bvalid_q, rvalid_q;
  logic [31:0]                 rdata_q, rdata_d;
  logic [31:0]                 wr_word;
  logic                        do_write, do_read;

  logic [TB_DIV_WIDTH-1:0]     tb_setting_q;
  logic                        tb_en_q, tb_ext_q, tb_pending;
  logic [N_CHAINS-1:0]         counter_run_q, counter_run_d;
  logic [STOP_STATE_WIDTH-1:0] stopped_state_q;

  logic [SYNC_CNT_W-1:0]       sync_cnt_q, sync_cnt_d;
  logic                        ctrl_sync_prev_q, ext_sync_prev_q, sync_trig;

  logic                        unused_bits;

  function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  // Address and data are accepted together; a new write waits until the response is taken.
  assign do_write       = axi_in_awvalid & axi_in_wvalid & ~bvalid_q;
  assign do_read        = axi_in_arvalid & ~rvalid_q;
  assign axi_in_awready = do_write;
  assign axi_in_wready  = do_write;
  assign axi_in_arready = ~rvalid_q;
  assign axi_in_bvalid  = bvalid_q;
  assign axi_in_bresp   = 2'b00;
  assign axi_in_rvalid  = rvalid_q;
  assign axi_in_rdata   = rdata_q;
  assign axi_in_rresp   = 2'b00;

  assign tb_pending = (ctrl_q[TB_DIV_WIDTH-1:0] != tb_setting_q) |
                      (ctrl_q[CTRL_TB_EN] != tb_en_q) |
                      (ctrl_q[CTRL_TB_EXT] != tb_ext_q);

  always_comb begin
    ctrl_d       = ctrl_q;
    stop_state_d = stop_state_q;
    run_mask_d   = run_mask_q;
    wr_word      = '0;
    if (do_write) begin
      case (axi_in_awaddr[3:2])
        2'd0: begin
          wr_word = strobe_merge(32'(ctrl_q), axi_in_wdata, axi_in_wstrb);
          ctrl_d  = wr_word[9:0];
        end
        2'd1: begin
          wr_word      = strobe_merge(32'(stop_state_q), axi_in_wdata, axi_in_wstrb);
          stop_state_d = wr_word[STOP_STATE_WIDTH-1:0];
        end
        2'd2: begin
          wr_word    = strobe_merge(32'(run_mask_q), axi_in_wdata, axi_in_wstrb);
          run_mask_d = wr_word[N_CHAINS-1:0];
        end
        default: wr_word = '0;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (axi_in_araddr[3:2])
      2'd0:    rdata_d = 32'(ctrl_q);
      2'd1:    rdata_d = 32'(stop_state_q);
      2'd2:    rdata_d = 32'(run_mask_q);
      default: rdata_d = {29'd0, tb_pending, state_q};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q       <= '0;
      stop_state_q <= '0;
      run_mask_q   <= '1;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      stop_state_q <= stop_state_d;
      run_mask_q   <= run_mask_d;
      if (do_write) begin
        bvalid_q <= 1'b1;
      end else if (axi_in_bready) begin
        bvalid_q <= 1'b0;
      end
      if (do_read) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (axi_in_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // counter_run is registered from the next state so it lines up with state_q.
  always_comb begin
    state_d       = state_q;
    counter_run_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_RUN]) begin
          state_d = ctrl_q[CTRL_EXT_START] ? ST_ARMED : ST_RUNNING;
        end
      end
      ST_ARMED: begin
        if (!ctrl_q[CTRL_RUN]) begin
          state_d = ST_IDLE;
        end else if (ext_start) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING: begin
        if (!ctrl_q[CTRL_RUN]) begin
          state_d = ctrl_q[CTRL_STOP_MODE] ? ST_STOPPING : ST_IDLE;
        end
      end
      default: begin
        if (ctrl_q[CTRL_RUN]) begin
          state_d = ST_RUNNING;
        end else if (period_end[0]) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    if (state_d == ST_RUNNING || state_d == ST_STOPPING) begin
      counter_run_d = run_mask_q;
    end
  end

  assign sync_trig = (ctrl_q[CTRL_SYNC] & ~ctrl_sync_prev_q) |
                     (ctrl_q[CTRL_EXT_SYNC] & ext_sync & ~ext_sync_prev_q);

  // Triggers seen while a pulse is still running are dropped, not queued.
  always_comb begin
    sync_cnt_d = sync_cnt_q;
    if (sync_cnt_q != '0) begin
      sync_cnt_d = sync_cnt_q - SYNC_CNT_W'(1);
    end else if (sync_trig) begin
      sync_cnt_d = SYNC_CNT_W'(SYNC_PULSE_LENGTH);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tb_setting_q     <= '0;
      tb_en_q          <= 1'b0;
      tb_ext_q         <= 1'b0;
      counter_run_q    <= '0;
      stopped_state_q  <= INITIAL_STOPPED_STATE;
      sync_cnt_q       <= '0;
      ctrl_sync_prev_q <= 1'b0;
      ext_sync_prev_q  <= 1'b0;
    end else begin
      if (~|counter_status) begin
        tb_setting_q <= ctrl_q[TB_DIV_WIDTH-1:0];
        tb_en_q      <= ctrl_q[CTRL_TB_EN];
        tb_ext_q     <= ctrl_q[CTRL_TB_EXT];
      end
      counter_run_q    <= counter_run_d;
      stopped_state_q  <= stop_state_q;
      sync_cnt_q       <= sync_cnt_d;
      ctrl_sync_prev_q <= ctrl_q[CTRL_SYNC];
      ext_sync_prev_q  <= ext_sync;
    end
  end

  assign timebase_setting         = tb_setting_q;
  assign timebase_enable          = tb_en_q;
  assign timebase_external_enable = tb_ext_q;
  assign counter_run              = counter_run_q;
  assign counter_stopped_state    = stopped_state_q;
  assign sync                     = (sync_cnt_q != '0);

  assign unused_bits = ^{wr_word, axi_in_awaddr[1:0], axi_in_araddr[1:0], period_end};

endmodule

// File: tb/tb_pwm_control_unit_v2.sv
// Bench for pwm_control_unit_v2: directed test-plan steps, then random traffic,
// all checked every cycle against a behavioural model of the control unit.
module tb_pwm_control_unit_v2;

  localparam int NC = 3;
  localparam int SSW = 12;
  localparam int TBW = 3;
  localparam int SPL = 4;
  localparam logic [SSW-1:0] INIT = 12'hA5C;

  localparam int ST_IDLE = 0;
  localparam int ST_ARMED = 1;
  localparam int ST_RUNNING = 2;
  localparam int ST_STOPPING = 3;

  logic clock = 1'b0;
  logic reset;
  logic [NC-1:0] counter_status, period_end, counter_run;
  logic ext_start, ext_sync, timebase_enable, timebase_external_enable, sync;
  logic [TBW-1:0] timebase_setting;
  logic [SSW-1:0] counter_stopped_state;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [3:0] awaddr, araddr, wstrb;
  logic [31:0] wdata, rdata;
  logic [1:0] bresp, rresp;

  always #5 clock = ~clock;

  pwm_control_unit_v2 #(
    .N_CHAINS(NC), .STOP_STATE_WIDTH(SSW), .TB_DIV_WIDTH(TBW),
    .SYNC_PULSE_LENGTH(SPL), .INITIAL_STOPPED_STATE(INIT)
  ) dut (
    .clock(clock), .reset(reset),
    .counter_status(counter_status), .period_end(period_end),
    .ext_start(ext_start), .ext_sync(ext_sync),
    .timebase_setting(timebase_setting), .timebase_enable(timebase_enable),
    .timebase_external_enable(timebase_external_enable),
    .counter_run(counter_run), .sync(sync), .counter_stopped_state(counter_stopped_state),
    .axi_in_awvalid(awvalid), .axi_in_awready(awready), .axi_in_awaddr(awaddr),
    .axi_in_wvalid(wvalid), .axi_in_wready(wready), .axi_in_wdata(wdata), .axi_in_wstrb(wstrb),
    .axi_in_bvalid(bvalid), .axi_in_bready(bready), .axi_in_bresp(bresp),
    .axi_in_arvalid(arvalid), .axi_in_arready(arready), .axi_in_araddr(araddr),
    .axi_in_rvalid(rvalid), .axi_in_rready(rready), .axi_in_rdata(rdata), .axi_in_rresp(rresp)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model: register contents, expected outputs, state number, sync window.
  int cyc = 0;
  int s_start = -1000;
  int m_state = ST_IDLE;
  logic [9:0] r_ctrl;
  logic [SSW-1:0] r_stop, o_stop;
  logic [NC-1:0] r_mask, o_run;
  logic [TBW-1:0] o_tb_set;
  logic o_tb_en, o_tb_ext, m_psync, m_pext;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit sync_on(input int c);
    return (c >= s_start) && (c < s_start + SPL);
  endfunction

  function automatic bit tb_pend();
    return (r_ctrl[2:0] != o_tb_set) || (r_ctrl[3] != o_tb_en) || (r_ctrl[4] != o_tb_ext);
  endfunction

  task automatic model_edge(input bit wr, input logic [3:0] a, input logic [31:0] d);
    int ns;
    bit run, trig;
    if (reset) begin
      r_ctrl = '0; r_stop = '0; r_mask = '1;
      o_tb_set = '0; o_tb_en = 0; o_tb_ext = 0; o_run = '0; o_stop = INIT;
      m_state = ST_IDLE; s_start = -1000; m_psync = 0; m_pext = 0;
    end else begin
      run = r_ctrl[5];
      if (counter_status == '0) begin
        o_tb_set = r_ctrl[2:0]; o_tb_en = r_ctrl[3]; o_tb_ext = r_ctrl[4];
      end
      o_stop = r_stop;
      ns = m_state;
      case (m_state)
        ST_IDLE:    if (run) ns = r_ctrl[8] ? ST_ARMED : ST_RUNNING;
        ST_ARMED:   if (!run) ns = ST_IDLE; else if (ext_start) ns = ST_RUNNING;
        ST_RUNNING: if (!run) ns = r_ctrl[7] ? ST_STOPPING : ST_IDLE;
        default:    if (run) ns = ST_RUNNING; else if (period_end[0]) ns = ST_IDLE;
      endcase
      m_state = ns;
      o_run = (ns == ST_RUNNING || ns == ST_STOPPING) ? r_mask : '0;
      trig = (r_ctrl[6] && !m_psync) || (r_ctrl[9] && ext_sync && !m_pext);
      if (trig && !sync_on(cyc)) s_start = cyc + 1;
      m_psync = r_ctrl[6];
      m_pext = ext_sync;
      if (wr) begin
        case (a)
          4'h0: r_ctrl = d[9:0];
          4'h4: r_stop = d[SSW-1:0];
          4'h8: r_mask = d[NC-1:0];
          default: ;
        endcase
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    chk("tb_setting", 32'(timebase_setting), 32'(o_tb_set));
    chk("tb_enable", 32'(timebase_enable), 32'(o_tb_en));
    chk("tb_ext_enable", 32'(timebase_external_enable), 32'(o_tb_ext));
    chk("counter_run", 32'(counter_run), 32'(o_run));
    chk("sync", 32'(sync), 32'(sync_on(cyc)));
    chk("stopped_state", 32'(counter_stopped_state), 32'(o_stop));
  endtask

  task automatic tick_w(input bit wr, input logic [3:0] a, input logic [31:0] d);
    @(posedge clock);
    model_edge(wr, a, d);
    #1;
    check_all();
  endtask

  task automatic tick();
    tick_w(0, 4'h0, 32'h0);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    bit ok = 0;
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (awready === 1'b1) begin
        tick_w(1, a, d);
        ok = 1;
      end else begin
        tick();
      end
    end
    awvalid = 0; wvalid = 0;
    chk("aw_handshake", 32'(ok), 32'd1);
  endtask

  task automatic read_status(output logic [31:0] got);
    bit ok = 0;
    logic [31:0] exp = '0;
    got = '0;
    araddr = 4'hC; arvalid = 1;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (arready === 1'b1) begin
        exp = {29'd0, tb_pend(), 2'(m_state)};
        tick();
        ok = 1;
        got = rdata;
        chk("rvalid", 32'(rvalid), 32'd1);
      end else begin
        tick();
      end
    end
    arvalid = 0;
    chk("ar_handshake", 32'(ok), 32'd1);
    chk("status_model", got, exp);
  endtask

  initial begin
    logic [31:0] st;
    int highs, rises;
    logic prev;
    reset = 1; counter_status = '0; period_end = '0; ext_start = 0; ext_sync = 0;
    awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0; wstrb = '0; bready = 1;
    arvalid = 0; araddr = '0; rready = 1;
    tick(); tick();
    chk("rst_tb_setting", 32'(timebase_setting), 32'd0);
    chk("rst_counter_run", 32'(counter_run), 32'd0);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_stopped", 32'(counter_stopped_state), 32'(INIT));
    reset = 0;
    tick();
    read_status(st);
    chk("rst_state", st, 32'd0);

    // 1: start with timebase settings
    axi_write(4'h0, 32'h2B);
    tick(); tick();
    chk("t1_setting", 32'(timebase_setting), 32'd3);
    chk("t1_tb_en", 32'(timebase_enable), 32'd1);
    chk("t1_run", 32'(counter_run), 32'h7);
    read_status(st);
    chk("t1_state", 32'(st[1:0]), 32'd2);

    // 2: timebase change deferred while counters busy
    counter_status = 3'b001;
    axi_write(4'h0, 32'h2D);
    tick();
    chk("t2_hold", 32'(timebase_setting), 32'd3);
    read_status(st);
    chk("t2_pending", 32'(st[2]), 32'd1);
    counter_status = '0;
    tick();
    chk("t2_loaded", 32'(timebase_setting), 32'd5);
    read_status(st);
    chk("t2_clear", 32'(st[2]), 32'd0);

    // 3: external start, and abort while armed
    axi_write(4'h0, 32'h0);
    axi_write(4'h0, 32'h120);
    tick();
    read_status(st);
    chk("t3_armed", 32'(st[1:0]), 32'd1);
    chk("t3_run_off", 32'(counter_run), 32'd0);
    ext_start = 1; tick(); ext_start = 0; tick();
    chk("t3_run_on", 32'(counter_run), 32'h7);
    read_status(st);
    chk("t3_running", 32'(st[1:0]), 32'd2);
    axi_write(4'h0, 32'h0);
    axi_write(4'h0, 32'h120);
    tick();
    axi_write(4'h0, 32'h100);
    ext_start = 1; tick(); ext_start = 0; tick();
    read_status(st);
    chk("t3_abort", 32'(st[1:0]), 32'd0);
    chk("t3_abort_run", 32'(counter_run), 32'd0);

    // 4: graceful stop on master period end only
    axi_write(4'h0, 32'hA0);
    tick();
    axi_write(4'h0, 32'h80);
    tick();
    chk("t4_run_kept", 32'(counter_run), 32'h7);
    read_status(st);
    chk("t4_stopping", 32'(st[1:0]), 32'd3);
    period_end = 3'b010; tick(); period_end = '0; tick();
    read_status(st);
    chk("t4_pe1_ignored", 32'(st[1:0]), 32'd3);
    period_end = 3'b001; tick(); period_end = '0; tick();
    chk("t4_run_off", 32'(counter_run), 32'd0);
    read_status(st);
    chk("t4_idle", 32'(st[1:0]), 32'd0);

    // 5: sync pulses
    axi_write(4'h0, 32'h40);
    highs = 0; rises = 0; prev = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sync === 1'b1) highs++;
      if (sync === 1'b1 && !prev) rises++;
      prev = sync;
    end
    chk("t5_sw_len", 32'(highs), 32'd4);
    chk("t5_sw_pulses", 32'(rises), 32'd1);
    axi_write(4'h0, 32'h200);
    highs = 0; rises = 0; prev = 0;
    for (int i = 0; i < 16; i++) begin
      ext_sync = (i == 0 || i == 2 || i == 8);
      tick();
      if (sync === 1'b1) highs++;
      if (sync === 1'b1 && !prev) rises++;
      prev = sync;
    end
    ext_sync = 0;
    chk("t5_ext_len", 32'(highs), 32'd8);
    chk("t5_ext_pulses", 32'(rises), 32'd2);

    // 6: live run mask, stop state, reset mid-pulse
    axi_write(4'h0, 32'h20);
    tick();
    axi_write(4'h8, 32'h5);
    tick();
    chk("t6_mask", 32'(counter_run), 32'h5);
    axi_write(4'h4, 32'h3C7);
    tick();
    chk("t6_stop_state", 32'(counter_stopped_state), 32'h3C7);
    axi_write(4'h0, 32'h60);
    tick();
    chk("t6_sync_on", 32'(sync), 32'd1);
    reset = 1;
    tick();
    chk("t6_rst_sync", 32'(sync), 32'd0);
    chk("t6_rst_run", 32'(counter_run), 32'd0);
    chk("t6_rst_stopped", 32'(counter_stopped_state), 32'(INIT));
    reset = 0;
    tick();

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      int r;
      counter_status = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      period_end = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      ext_start = ($urandom_range(0, 3) == 0);
      ext_sync = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 15) begin
        axi_write(4'(4 * $urandom_range(0, 2)), $urandom);
      end else if (r < 20) begin
        read_status(st);
      end else if (r == 99) begin
        reset = 1;
        tick();
        reset = 0;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
